id_ex_stage: RTL

- ID/EX pipeline register for the 16-bit pipelined MIPS core.
- Sits directly downstream of the register file. Captures Read_Data1/Read_Data2, the decoded immediate, the destination register and the control bundle, and presents them to EX.
- Contains load-use hazard detection: it stalls the front end and inserts a bubble.
- Handles branch flush and keeps a saturating stall-cycle counter.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/hazard_detect.sv | 34 +++
 rtl/id_ex_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipelined MIPS core: datapath widths,
// control-bundle bit layout and ALU operation encodings.
package pipe_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int CTRL_W     = 8;

  localparam int CTRL_REGWRITE  = 7;
  localparam int CTRL_MEMREAD   = 6;
  localparam int CTRL_MEMWRITE  = 5;
  localparam int CTRL_MEMTOREG  = 4;
  localparam int CTRL_ALUSRC    = 3;
  localparam int CTRL_ALUOP_LSB = 0;
  localparam int ALUOP_W        = 3;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  // A bundle whose MemRead bit is set produces its result only after MEM.
  function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

  function automatic alu_op_e ctrl_alu_op(input logic [CTRL_W-1:0] ctrl);
    return alu_op_e'(ctrl[CTRL_ALUOP_LSB +: ALUOP_W]);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
// Purely combinational; a flush overrides any stall request.
module hazard_detect #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int CTRL_W     = pipe_pkg::CTRL_W
) (
  input  logic                  Ex_Valid,
  input  logic [CTRL_W-1:0]     Ex_Ctrl,
  input  logic [REG_ADDR_W-1:0] Ex_Dst,
  input  logic [REG_ADDR_W-1:0] Src1,
  input  logic [REG_ADDR_W-1:0] Src2,
  input  logic                  Uses_Src1,
  input  logic                  Uses_Src2,
  input  logic                  Id_Valid,
  input  logic                  Flush,
  output logic                  Stall
);
  import pipe_pkg::*;

  logic ex_is_load;
  logic src1_match;
  logic src2_match;
  logic hazard;

  // R0 is an ordinary register in this core, so it takes part in matching.
  always_comb begin
    ex_is_load = Ex_Valid & ctrl_is_load(Ex_Ctrl);
    src1_match = Uses_Src1 & (Src1 == Ex_Dst);
    src2_match = Uses_Src2 & (Src2 == Ex_Dst);
    hazard     = ex_is_load & Id_Valid & (src1_match | src2_match);
    Stall      = hazard & ~Flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and a
// saturating count of inserted stall bubbles.
module id_ex_stage #(
  parameter int DATA_W     = pipe_pkg::DATA_W,
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int CTRL_W     = pipe_pkg::CTRL_W,
  parameter int CNT_W      = 16
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [DATA_W-1:0]     Read_Data1,
  input  logic [DATA_W-1:0]     Read_Data2,
  input  logic [REG_ADDR_W-1:0] Src1,
  input  logic [REG_ADDR_W-1:0] Src2,
  input  logic                  Uses_Src1,
  input  logic                  Uses_Src2,
  input  logic [REG_ADDR_W-1:0] Dst_In,
  input  logic [DATA_W-1:0]     Imm_In,
  input  logic [CTRL_W-1:0]     Ctrl_In,
  input  logic                  Id_Valid,
  input  logic                  Flush,
  output logic [DATA_W-1:0]     Ex_Data1,
  output logic [DATA_W-1:0]     Ex_Data2,
  output logic [DATA_W-1:0]     Ex_Imm,
  output logic [REG_ADDR_W-1:0] Ex_Src1,
  output logic [REG_ADDR_W-1:0] Ex_Src2,
  output logic [REG_ADDR_W-1:0] Ex_Dst,
  output logic [CTRL_W-1:0]     Ex_Ctrl,
  output logic                  Ex_Valid,
  output logic                  Stall,
  output logic [CNT_W-1:0]      Stall_Count
);

  logic bubble;
  logic count_sat;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W),
    .CTRL_W     (CTRL_W)
  ) u_hazard (
    .Ex_Valid  (Ex_Valid),
    .Ex_Ctrl   (Ex_Ctrl),
    .Ex_Dst    (Ex_Dst),
    .Src1      (Src1),
    .Src2      (Src2),
    .Uses_Src1 (Uses_Src1),
    .Uses_Src2 (Uses_Src2),
    .Id_Valid  (Id_Valid),
    .Flush     (Flush),
    .Stall     (Stall)
  );

  assign bubble    = Flush | Stall;
  assign count_sat = &Stall_Count;

  // On a bubble the data fields keep their old contents; only valid and
  // control are cleared, which is enough to make the slot harmless.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      Ex_Data1 <= '0;
      Ex_Data2 <= '0;
      Ex_Imm   <= '0;
      Ex_Src1  <= '0;
      Ex_Src2  <= '0;
      Ex_Dst   <= '0;
      Ex_Ctrl  <= '0;
      Ex_Valid <= 1'b0;
    end else if (bubble) begin
      Ex_Ctrl  <= '0;
      Ex_Valid <= 1'b0;
    end else begin
      Ex_Data1 <= Read_Data1;
      Ex_Data2 <= Read_Data2;
      Ex_Imm   <= Imm_In;
      Ex_Src1  <= Src1;
      Ex_Src2  <= Src2;
      Ex_Dst   <= Dst_In;
      Ex_Ctrl  <= Id_Valid ? Ctrl_In : '0;
      Ex_Valid <= Id_Valid;
    end
  end

  // Stall already excludes flush cycles, so flushes never add to the count.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      Stall_Count <= '0;
    end else if (Stall && !count_sat) begin
      Stall_Count <= Stall_Count + CNT_W'(1);
    end
  end

endmodule
